// File: rtl/reg_bank_writer.sv
// 32 x 32-bit register bank with single-port write decode and a sequential clear FSM.
// Define REG0_ZERO_EN to make register 0 read as constant zero (writes to it are acked but dropped).
module reg_bank_writer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        WrEn,
  input  logic [4:0]  WrAddr,
  input  logic [31:0] WrData,
  input  logic        ClrReq,
  output logic        Busy,
  output logic        WrAck,
  output logic        dbg_state,
  output logic [31:0] R0,  output logic [31:0] R1,  output logic [31:0] R2,  output logic [31:0] R3,
  output logic [31:0] R4,  output logic [31:0] R5,  output logic [31:0] R6,  output logic [31:0] R7,
  output logic [31:0] R8,  output logic [31:0] R9,  output logic [31:0] R10, output logic [31:0] R11,
  output logic [31:0] R12, output logic [31:0] R13, output logic [31:0] R14, output logic [31:0] R15,
  output logic [31:0] R16, output logic [31:0] R17, output logic [31:0] R18, output logic [31:0] R19,
  output logic [31:0] R20, output logic [31:0] R21, output logic [31:0] R22, output logic [31:0] R23,
  output logic [31:0] R24, output logic [31:0] R25, output logic [31:0] R26, output logic [31:0] R27,
  output logic [31:0] R28, output logic [31:0] R29, output logic [31:0] R30, output logic [31:0] R31
);

  // Handshake: WrEn is a one-cycle request sampled at the rising edge while idle;
  // WrAck pulses for the single cycle after an accepted write. No backpressure.

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

`ifdef REG0_ZERO_EN
  localparam bit ZERO0 = 1'b1;
`else
  localparam bit ZERO0 = 1'b0;
`endif

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic        ack_next;
  logic        wr_go;
  logic        clr_go;
  logic [31:0][31:0] bank;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      WrAck <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      WrAck <= ack_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ack_next   = 1'b0;
    wr_go      = 1'b0;
    clr_go     = 1'b0;
    case (state)
      IDLE: begin
        // A clear request beats a same-cycle write; the write is dropped unacked.
        if (ClrReq) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end else if (WrEn) begin
          wr_go    = 1'b1;
          ack_next = 1'b1;
        end
      end
      CLEAR: begin
        clr_go   = 1'b1;
        cnt_next = cnt + 5'd1;
        if (cnt == 5'd31) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy      = (state == CLEAR);
  assign dbg_state = state;

  for (genvar g = 0; g < 32; g++) begin : g_reg
    if (ZERO0 && g == 0) begin : g_zero
      assign bank[g] = '0;
    end else begin : g_ff
      logic [31:0] q;
      always_ff @(posedge Clk) begin
        if (Rst)                          q <= '0;
        else if (clr_go && cnt == 5'(g))  q <= '0;
        else if (wr_go && WrAddr == 5'(g)) q <= WrData;
      end
      assign bank[g] = q;
    end
  end

  assign R0  = bank[0];  assign R1  = bank[1];  assign R2  = bank[2];  assign R3  = bank[3];
  assign R4  = bank[4];  assign R5  = bank[5];  assign R6  = bank[6];  assign R7  = bank[7];
  assign R8  = bank[8];  assign R9  = bank[9];  assign R10 = bank[10]; assign R11 = bank[11];
  assign R12 = bank[12]; assign R13 = bank[13]; assign R14 = bank[14]; assign R15 = bank[15];
  assign R16 = bank[16]; assign R17 = bank[17]; assign R18 = bank[18]; assign R19 = bank[19];
  assign R20 = bank[20]; assign R21 = bank[21]; assign R22 = bank[22]; assign R23 = bank[23];
  assign R24 = bank[24]; assign R25 = bank[25]; assign R26 = bank[26]; assign R27 = bank[27];
  assign R28 = bank[28]; assign R29 = bank[29]; assign R30 = bank[30]; assign R31 = bank[31];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: cycle-level reference model feeding an expected queue.
// Honours REG0_ZERO_EN the same way the design does.
module tb_reg_bank_writer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;
  logic        ClrReq;
  logic        Busy;
  logic        WrAck;
  logic        dbg_state;
  logic [31:0] r [32];

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_busy;
  logic        m_ack;
  logic [4:0]  m_cnt;
  logic [2:0]  exp_q [$];

`ifdef REG0_ZERO_EN
  localparam bit ZERO0 = 1'b1;
`else
  localparam bit ZERO0 = 1'b0;
`endif

  always #5 Clk = ~Clk;

  reg_bank_writer dut (
    .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .ClrReq(ClrReq),
    .Busy(Busy), .WrAck(WrAck), .dbg_state(dbg_state),
    .R0(r[0]),   .R1(r[1]),   .R2(r[2]),   .R3(r[3]),   .R4(r[4]),   .R5(r[5]),   .R6(r[6]),   .R7(r[7]),
    .R8(r[8]),   .R9(r[9]),   .R10(r[10]), .R11(r[11]), .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
    .R16(r[16]), .R17(r[17]), .R18(r[18]), .R19(r[19]), .R20(r[20]), .R21(r[21]), .R22(r[22]), .R23(r[23]),
    .R24(r[24]), .R25(r[25]), .R26(r[26]), .R27(r[27]), .R28(r[28]), .R29(r[29]), .R30(r[30]), .R31(r[31])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic predict(input logic rst_i, input logic wr_i, input logic [4:0] a,
                         input logic [31:0] d, input logic clr_i);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = 1'b0; m_ack = 1'b0; m_cnt = '0;
    end else if (!m_busy) begin
      m_ack = 1'b0;
      if (clr_i) begin
        m_busy = 1'b1; m_cnt = '0;
      end else if (wr_i) begin
        m_ack = 1'b1;
        if (!(ZERO0 && a == 5'd0)) m_regs[a] = d;
      end
    end else begin
      m_ack = 1'b0;
      m_regs[m_cnt] = '0;
      if (m_cnt == 5'd31) m_busy = 1'b0;
      m_cnt = m_cnt + 5'd1;
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic rst_i, input logic wr_i, input logic [4:0] a,
                      input logic [31:0] d, input logic clr_i);
    logic [2:0] e;
    @(negedge Clk);
    Rst = rst_i; WrEn = wr_i; WrAddr = a; WrData = d; ClrReq = clr_i;
    predict(rst_i, wr_i, a, d, clr_i);
    exp_q.push_back({m_busy, m_busy, m_ack});
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check("busy",  {31'd0, Busy},      {31'd0, e[2]});
    check("state", {31'd0, dbg_state}, {31'd0, e[1]});
    check("wrack", {31'd0, WrAck},     {31'd0, e[0]});
    for (int i = 0; i < 32; i++) check($sformatf("r%0d", i), r[i], m_regs[i]);
    if (Busy) busy_cycles++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic fill(input logic [31:0] d);
    for (int a = 0; a < 32; a++) wr(5'(a), d);
  endtask

  initial begin
    Rst = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0; ClrReq = 1'b0;
    busy_cycles = 0;

    // Reset state
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 32'h1111_1111, 1'b1);
    idle();

    // Single write, then confirm the ack is a single pulse
    wr(5'd5, 32'hDEAD_BEEF);
    idle();

    // Back-to-back writes over every address
    for (int a = 0; a < 32; a++) wr(5'(a), 32'h1000 + 32'(a));
    idle();

    // Random writes, some back-to-back, some with gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else wr(5'($urandom_range(0, 31)), $urandom);
    end

    // Full clear from all-ones
    fill(32'hFFFF_FFFF);
    busy_cycles = 0;
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    for (int c = 0; c < 40 && (m_busy || Busy); c++) idle();
    check("clear_len", 32'(busy_cycles), 32'd32);
    idle();

    // Writes and clear requests during CLEAR are ignored
    fill(32'h5A5A_0000);
    busy_cycles = 0;
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    for (int c = 0; c < 40 && (m_busy || Busy); c++) begin
      if (c == 3)       wr(5'd31, 32'h1234_5678);
      else if (c == 10) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      else if (c == 20) step(1'b0, 1'b1, 5'd9, 32'h9999_9999, 1'b1);
      else              idle();
    end
    check("clear_len_ign", 32'(busy_cycles), 32'd32);
    check("r31_after", r[31], 32'd0);
    idle();

    // Same-cycle write and clear: clear wins
    wr(5'd7, 32'h0BAD_F00D);
    busy_cycles = 0;
    step(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1);
    for (int c = 0; c < 40 && (m_busy || Busy); c++) idle();
    check("clear_len_race", 32'(busy_cycles), 32'd32);
    check("r7_after", r[7], 32'd0);
    idle();

    // Reset aborts a clear mid-sequence
    fill(32'h3C3C_3C3C);
    wr(5'd20, 32'hCAFE_F00D);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    for (int c = 0; c < 12; c++) idle();
    step(1'b1, 1'b1, 5'd4, 32'h4444_4444, 1'b1);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_r20", r[20], 32'd0);
    wr(5'd2, 32'h2222_2222);
    idle();

    // Register 0 behaviour and a final write after everything
    wr(5'd0, 32'hFEED_FACE);
    idle();
    wr(5'd31, 32'h3131_3131);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
